cnn_win3x3: RTL and testbench

Streaming 3x3 window generator sitting directly downstream of `cnn_ctrl`. It consumes the raster pixel stream qualified by `ctrl_data_run`, `row`, `col` and `end_frame`, stores the two previous image lines in on-chip line memories, and presents a full 3x3 pixel window every time a new pixel completes one. Windows are causal: the bottom-right tap is the current pixel, and no padding is applied. A W x H frame therefore yields (W-2) x (H-2) valid windows, which feed the CNN convolution datapath.

---
 rtl/cnn_win3x3.sv | 109 ++++++++++
 tb/tb_cnn_win3x3.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_win3x3.sv
`timescale 1ns/1ps
// Causal 3x3 window generator over a raster pixel stream, two line memories deep.
// Window updates on the accepting edge (1-cycle latency); no backpressure, 1 pixel/cycle.
module cnn_win3x3 #(
  parameter int W_SIZE       = 12,
  parameter int W_FRAME_SIZE = 25,
  parameter int DATA_W       = 8,
  parameter int MAX_WIDTH    = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_data_run,
  input  logic [W_SIZE-1:0]       i_row,
  input  logic [W_SIZE-1:0]       i_col,
  input  logic [DATA_W-1:0]       i_pixel,
  input  logic                    i_end_frame,
  output logic                    o_valid,
  output logic [9*DATA_W-1:0]     o_win,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic                    o_end_frame,
  output logic [W_FRAME_SIZE-1:0] o_frame_wins,
  output logic                    o_overflow
);

  localparam int                AW      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [W_SIZE:0]   MAX_COL = (W_SIZE+1)'(MAX_WIDTH);
  localparam logic [W_SIZE-1:0] TWO     = W_SIZE'(2);

  logic [DATA_W-1:0]       lb0 [MAX_WIDTH];
  logic [DATA_W-1:0]       lb1 [MAX_WIDTH];
  logic [DATA_W-1:0]       tap_q [3][3];
  logic [AW-1:0]           addr;
  logic                    in_range;
  logic                    accept;
  logic                    win_set;
  logic [W_FRAME_SIZE-1:0] win_cnt;

  assign in_range = ({1'b0, i_col} < MAX_COL);
  assign accept   = i_data_run && in_range;
  assign addr     = i_col[AW-1:0];
  assign win_set  = accept && (i_row >= TWO) && (i_col >= TWO);

  // Line memories carry no reset; stale contents are masked by the row/col>=2 rule.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= i_pixel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap_q[r][c] <= '0;
        end
      end
      o_valid <= 1'b0;
      o_row   <= '0;
      o_col   <= '0;
    end else begin
      o_valid <= win_set;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          tap_q[r][0] <= tap_q[r][1];
          tap_q[r][1] <= tap_q[r][2];
        end
        tap_q[0][2] <= lb1[addr];
        tap_q[1][2] <= lb0[addr];
        tap_q[2][2] <= i_pixel;
        o_row       <= i_row;
        o_col       <= i_col;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_overflow <= 1'b0;
    end else if (i_data_run && !in_range) begin
      o_overflow <= 1'b1;
    end
  end

  // A window issued on the end-of-frame cycle still belongs to the finishing frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_cnt      <= '0;
      o_frame_wins <= '0;
      o_end_frame  <= 1'b0;
    end else begin
      o_end_frame <= i_end_frame;
      if (i_end_frame) begin
        o_frame_wins <= win_cnt + W_FRAME_SIZE'(win_set);
        win_cnt      <= '0;
      end else if (win_set) begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign o_win[DATA_W*(3*r+c) +: DATA_W] = tap_q[r][c];
    end
  end

endmodule

// File: tb/tb_cnn_win3x3.sv
`timescale 1ns/1ps
// Randomized bench for cnn_win3x3 against an image-array reference model.
module tb_cnn_win3x3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_data_run;
  logic [11:0] i_row;
  logic [11:0] i_col;
  logic [7:0]  i_pixel;
  logic        i_end_frame;
  logic        o_valid;
  logic [71:0] o_win;
  logic [11:0] o_row;
  logic [11:0] o_col;
  logic        o_end_frame;
  logic [24:0] o_frame_wins;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  // Reference image of the frame being streamed, indexed [row][col].
  logic [7:0] img [128][256];

  cnn_win3x3 dut (
    .clk(clk), .rstn(rstn), .i_data_run(i_data_run), .i_row(i_row), .i_col(i_col),
    .i_pixel(i_pixel), .i_end_frame(i_end_frame), .o_valid(o_valid), .o_win(o_win),
    .o_row(o_row), .o_col(o_col), .o_end_frame(o_end_frame),
    .o_frame_wins(o_frame_wins), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drive one cycle, then sample 1ns after the edge.
  task automatic step(input logic run, input int r, input int c, input logic [7:0] p,
                      input logic ef);
    i_data_run  = run;
    i_row       = 12'(r);
    i_col       = 12'(c);
    i_pixel     = p;
    i_end_frame = ef;
    if (run && c < 256 && r < 128) img[r][c] = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[8*(3*rr+cc) +: 8] = img[r-2+rr][c-2+cc];
    return w;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; i_data_run = 0; i_row = 0; i_col = 0; i_pixel = 0; i_end_frame = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_win !== 72'd0) begin errors++; $display("FAIL reset_win got %h want 0", o_win); end
    checks++; if (o_row !== 12'd0) begin errors++; $display("FAIL reset_row got %0d want 0", o_row); end
    checks++; if (o_col !== 12'd0) begin errors++; $display("FAIL reset_col got %0d want 0", o_col); end
    checks++; if (o_end_frame !== 1'b0) begin errors++; $display("FAIL reset_end_frame got %b want 0", o_end_frame); end
    checks++; if (o_frame_wins !== 25'd0) begin errors++; $display("FAIL reset_frame_wins got %0d want 0", o_frame_wins); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", o_overflow); end
    rstn = 1'b1;
    step(0, 0, 0, 8'd0, 0);
  endtask

  task automatic test_ramp();
    int tv[9] = '{0, 1, 2, 128, 129, 130, 0, 1, 2};
    logic [71:0] first_exp;
    logic ev;
    bit seen;
    seen = 0;
    for (int k = 0; k < 9; k++) first_exp[8*k +: 8] = 8'(tv[k]);
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        if ($urandom_range(0, 15) == 0) begin
          step(0, r, c, 8'd0, 0);
          checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ramp_gap_valid got %b want 0", o_valid); end
        end
        step(1, r, c, 8'((r*128 + c) % 256), 0);
        ev = (r >= 2 && c >= 2);
        checks++; if (o_valid !== ev) begin errors++; $display("FAIL ramp_valid (%0d,%0d) got %b want %b", r, c, o_valid, ev); end
        if (ev) begin
          checks++;
          if (o_win !== exp_win(r, c) || o_row !== 12'(r) || o_col !== 12'(c)) begin
            errors++; $display("FAIL ramp_win (%0d,%0d) got %h @(%0d,%0d) want %h", r, c, o_win, o_row, o_col, exp_win(r, c));
          end
        end
        if (!seen && o_valid === 1'b1) begin
          seen = 1;
          checks++;
          if (o_row !== 12'd2 || o_col !== 12'd2 || o_win !== first_exp) begin
            errors++; $display("FAIL ramp_first_win got %h @(%0d,%0d) want %h @(2,2)", o_win, o_row, o_col, first_exp);
          end
        end
      end
    end
    step(0, 127, 127, 8'd0, 1);
    checks++; if (o_end_frame !== 1'b1) begin errors++; $display("FAIL ramp_end_frame got %b want 1", o_end_frame); end
    checks++; if (o_frame_wins !== 25'd15876) begin errors++; $display("FAIL ramp_frame_wins got %0d want 15876", o_frame_wins); end
    step(0, 127, 127, 8'd0, 0);
    checks++; if (o_end_frame !== 1'b0) begin errors++; $display("FAIL ramp_end_frame_pulse got %b want 0", o_end_frame); end
  endtask

  task automatic test_sync_gaps();
    int cnt;
    int want;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0, 8'd0, 0);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL vsync_valid got %b want 0", o_valid); end
    end
    for (int r = 0; r < 128; r++) begin
      cnt = 0;
      for (int c = 0; c < 128; c++) begin
        step(1, r, c, 8'($urandom), 0);
        if (o_valid === 1'b1) begin
          cnt++;
          checks++;
          if (o_win !== exp_win(r, c)) begin
            errors++; $display("FAIL sync_win (%0d,%0d) got %h want %h", r, c, o_win, exp_win(r, c));
          end
        end
      end
      for (int i = 0; i < 160; i++) begin
        step(0, r, 127, 8'd0, 0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hsync_valid row %0d got %b want 0", r, o_valid); end
      end
      want = (r >= 2) ? 126 : 0;
      checks++; if (cnt != want) begin errors++; $display("FAIL sync_row_count row %0d got %0d want %0d", r, cnt, want); end
    end
    step(0, 127, 127, 8'd0, 1);
    checks++; if (o_frame_wins !== 25'd15876) begin errors++; $display("FAIL sync_frame_wins got %0d want 15876", o_frame_wins); end
  endtask

  task automatic test_back_to_back();
    logic ev;
    logic ef;
    int early;
    early = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          ef = (f == 1) && ((r == 0 && c == 0) || (r == 7 && c == 7));
          step(1, r, c, 8'($urandom), ef);
          ev = (r >= 2 && c >= 2);
          checks++; if (o_valid !== ev) begin errors++; $display("FAIL b2b_valid f%0d (%0d,%0d) got %b want %b", f, r, c, o_valid, ev); end
          if (ev) begin
            checks++;
            if (o_win !== exp_win(r, c)) begin errors++; $display("FAIL b2b_win f%0d (%0d,%0d) got %h want %h", f, r, c, o_win, exp_win(r, c)); end
          end
          if (f == 1 && r < 2 && o_valid === 1'b1) early++;
          if (f == 1 && r == 0 && c == 0) begin
            checks++;
            if (o_end_frame !== 1'b1 || o_frame_wins !== 25'd36) begin
              errors++; $display("FAIL b2b_frame1_wins got ef=%b wins=%0d want ef=1 wins=36", o_end_frame, o_frame_wins);
            end
          end
          if (f == 1 && r == 7 && c == 7) begin
            checks++;
            if (o_valid !== 1'b1 || o_end_frame !== 1'b1 || o_frame_wins !== 25'd36) begin
              errors++; $display("FAIL b2b_last_pixel_wins got v=%b ef=%b wins=%0d want v=1 ef=1 wins=36", o_valid, o_end_frame, o_frame_wins);
            end
          end
        end
      end
    end
    checks++; if (early != 0) begin errors++; $display("FAIL b2b_early_rows got %0d want 0", early); end
    step(0, 7, 7, 8'd0, 0);
    checks++; if (o_end_frame !== 1'b0 || o_frame_wins !== 25'd36) begin
      errors++; $display("FAIL b2b_hold got ef=%b wins=%0d want ef=0 wins=36", o_end_frame, o_frame_wins);
    end
  endtask

  task automatic test_overflow();
    logic ev;
    logic [71:0] saved;
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_initial got %b want 0", o_overflow); end
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        step(1, r, c, 8'($urandom), 0);
        ev = (r >= 2 && c >= 2);
        checks++; if (o_valid !== ev) begin errors++; $display("FAIL ovf_valid (%0d,%0d) got %b want %b", r, c, o_valid, ev); end
        if (ev) begin
          checks++;
          if (o_win !== exp_win(r, c)) begin errors++; $display("FAIL ovf_win (%0d,%0d) got %h want %h", r, c, o_win, exp_win(r, c)); end
        end
        if (r == 4 && c == 3) begin
          saved = o_win;
          step(1, 4, 256, 8'($urandom), 0);
          checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", o_overflow); end
          checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovf_drop_valid got %b want 0", o_valid); end
          checks++; if (o_win !== saved || o_col !== 12'd3) begin
            errors++; $display("FAIL ovf_win_hold got %h col %0d want %h col 3", o_win, o_col, saved);
          end
        end
      end
    end
    step(0, 5, 7, 8'd0, 1);
    checks++; if (o_frame_wins !== 25'd24) begin errors++; $display("FAIL ovf_frame_wins got %0d want 24", o_frame_wins); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", o_overflow); end
  endtask

  task automatic test_reset_mid_frame();
    logic ev;
    bit seen;
    seen = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (!(r == 5 && c > 7)) step(1, r, c, 8'($urandom), 0);
      end
    end
    i_data_run = 0;
    rstn = 1'b0;
    #2;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", o_valid); end
    checks++; if (o_win !== 72'd0) begin errors++; $display("FAIL mid_reset_win got %h want 0", o_win); end
    checks++; if (o_row !== 12'd0 || o_col !== 12'd0) begin errors++; $display("FAIL mid_reset_rowcol got (%0d,%0d) want (0,0)", o_row, o_col); end
    checks++; if (o_end_frame !== 1'b0) begin errors++; $display("FAIL mid_reset_end_frame got %b want 0", o_end_frame); end
    checks++; if (o_frame_wins !== 25'd0) begin errors++; $display("FAIL mid_reset_frame_wins got %0d want 0", o_frame_wins); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow got %b want 0", o_overflow); end
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 16; c++) begin
        step(1, r, c, 8'($urandom), 0);
        ev = (r >= 2 && c >= 2);
        checks++; if (o_valid !== ev) begin errors++; $display("FAIL restart_valid (%0d,%0d) got %b want %b", r, c, o_valid, ev); end
        if (ev) begin
          checks++;
          if (o_win !== exp_win(r, c)) begin errors++; $display("FAIL restart_win (%0d,%0d) got %h want %h", r, c, o_win, exp_win(r, c)); end
        end
        if (!seen && o_valid === 1'b1) begin
          seen = 1;
          checks++;
          if (o_row !== 12'd2 || o_col !== 12'd2) begin errors++; $display("FAIL restart_first got (%0d,%0d) want (2,2)", o_row, o_col); end
        end
      end
    end
    step(0, 5, 15, 8'd0, 1);
    checks++; if (o_frame_wins !== 25'd56) begin errors++; $display("FAIL restart_frame_wins got %0d want 56", o_frame_wins); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_sync_gaps();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
